// File: rtl/mac_lane_array.sv
// mac_lane_array: pipelined LANES-wide multiply-accumulate with in_last group framing.
// Define MAC_SATURATE_EN for a saturating accumulator; otherwise the accumulator wraps.
module mac_lane_array #(
  parameter int DW     = 4,
  parameter int LANES  = 4,
  parameter int AW     = 12,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  clr,
  input  logic [LANES*DW-1:0]   in1_IFM,
  input  logic [LANES*DW-1:0]   in2_IFM,
  output logic                  out_valid,
  output logic [AW-1:0]         Out_OFM,
  output logic                  ovf
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + $clog2(LANES);
  localparam int XW = AW + 2;

  function automatic logic [PW-1:0] mul_lane(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{DW{(SIGNED != 0) & a[DW-1]}}, a};
    bx = {{DW{(SIGNED != 0) & b[DW-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [SW-1:0] ext_prod(input logic [PW-1:0] p);
    logic [SW-1:0] r;
    r = ((SIGNED != 0) && p[PW-1]) ? {SW{1'b1}} : {SW{1'b0}};
    r[PW-1:0] = p;
    return r;
  endfunction

  function automatic logic [XW-1:0] ext_sum(input logic [SW-1:0] s);
    logic [XW-1:0] r;
    r = ((SIGNED != 0) && s[SW-1]) ? {XW{1'b1}} : {XW{1'b0}};
    r[SW-1:0] = s;
    return r;
  endfunction

  function automatic logic [XW-1:0] ext_acc(input logic [AW-1:0] v);
    logic [XW-1:0] r;
    r = ((SIGNED != 0) && v[AW-1]) ? {XW{1'b1}} : {XW{1'b0}};
    r[AW-1:0] = v;
    return r;
  endfunction

`ifdef MAC_SATURATE_EN
  localparam logic [AW-1:0] ACC_MAX = (SIGNED != 0) ? {1'b0, {(AW-1){1'b1}}} : {AW{1'b1}};
  localparam logic [AW-1:0] ACC_MIN = (SIGNED != 0) ? {1'b1, {(AW-1){1'b0}}} : {AW{1'b0}};
`endif

  logic                  first_r;
  logic                  p1_valid_r, p1_last_r, p1_first_r;
  logic [LANES*PW-1:0]   p1_prod_r;
  logic                  p2_valid_r, p2_last_r, p2_first_r;
  logic [SW-1:0]         p2_sum_r;
  logic [AW-1:0]         acc_r;
  logic                  ovf_acc_r;

  logic [LANES*PW-1:0]   prod_s;
  logic [SW-1:0]         sum_s;
  logic [XW-1:0]         base_s, wide_s;
  logic                  base_ovf_s, step_ovf_s, ovf_next_s;
  logic [AW-1:0]         acc_next_s;

  // Per-lane products of the incoming beat.
  always_comb begin
    prod_s = {(LANES*PW){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      prod_s[i*PW +: PW] = mul_lane(in1_IFM[i*DW +: DW], in2_IFM[i*DW +: DW]);
    end
  end

  // Reduction of the registered products; the true sum always fits SW bits.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + ext_prod(p1_prod_r[i*PW +: PW]);
    end
  end

  // Next accumulator value, computed two bits wider than AW so range escapes are visible.
  always_comb begin
    if (p2_first_r) begin
      base_s     = {XW{1'b0}};
      base_ovf_s = 1'b0;
    end else begin
      base_s     = ext_acc(acc_r);
      base_ovf_s = ovf_acc_r;
    end
    wide_s = base_s + ext_sum(p2_sum_r);
    if (SIGNED != 0) begin
      step_ovf_s = !((&wide_s[XW-1:AW-1]) || !(|wide_s[XW-1:AW-1]));
    end else begin
      step_ovf_s = |wide_s[XW-1:AW];
    end
    ovf_next_s = base_ovf_s | step_ovf_s;
`ifdef MAC_SATURATE_EN
    if (base_ovf_s) begin
      acc_next_s = acc_r;
    end else if (step_ovf_s) begin
      acc_next_s = wide_s[XW-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next_s = wide_s[AW-1:0];
    end
`else
    acc_next_s = wide_s[AW-1:0];
`endif
  end

  // P1 capture and first-beat tracking; a beat alongside clr opens a new group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_r    <= 1'b1;
      p1_valid_r <= 1'b0;
      p1_last_r  <= 1'b0;
      p1_first_r <= 1'b0;
      p1_prod_r  <= {(LANES*PW){1'b0}};
    end else begin
      p1_valid_r <= in_valid;
      if (in_valid) begin
        p1_last_r  <= in_last;
        p1_first_r <= first_r | clr;
        p1_prod_r  <= prod_s;
        first_r    <= in_last;
      end else if (clr) begin
        first_r <= 1'b1;
      end
    end
  end

  // P2 registered tree sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_valid_r <= 1'b0;
      p2_last_r  <= 1'b0;
      p2_first_r <= 1'b0;
      p2_sum_r   <= {SW{1'b0}};
    end else begin
      p2_valid_r <= p1_valid_r & ~clr;
      if (p1_valid_r) begin
        p2_last_r  <= p1_last_r;
        p2_first_r <= p1_first_r;
        p2_sum_r   <= sum_s;
      end
    end
  end

  // P3 accumulator and result register; a result already in P3 survives clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {AW{1'b0}};
      ovf_acc_r <= 1'b0;
      out_valid <= 1'b0;
      Out_OFM   <= {AW{1'b0}};
      ovf       <= 1'b0;
    end else begin
      if (clr) begin
        acc_r     <= {AW{1'b0}};
        ovf_acc_r <= 1'b0;
      end else if (p2_valid_r) begin
        acc_r     <= acc_next_s;
        ovf_acc_r <= ovf_next_s;
      end
      out_valid <= p2_valid_r & p2_last_r;
      if (p2_valid_r && p2_last_r) begin
        Out_OFM <= acc_next_s;
        ovf     <= ovf_next_s;
      end
    end
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: an unsigned and a signed instance share stimulus and are
// compared every cycle against a beat-queue arithmetic model (honours MAC_SATURATE_EN).
module tb_mac_lane_array;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, clr;
  logic [15:0] in1_IFM, in2_IFM;
  logic        out_valid_u, ovf_u, out_valid_s, ovf_s;
  logic [11:0] out_u, out_s;

  always #5 clk = ~clk;

  mac_lane_array #(.DW(4), .LANES(4), .AW(12), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .clr(clr),
    .in1_IFM(in1_IFM), .in2_IFM(in2_IFM),
    .out_valid(out_valid_u), .Out_OFM(out_u), .ovf(ovf_u));

  mac_lane_array #(.DW(4), .LANES(4), .AW(12), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .clr(clr),
    .in1_IFM(in1_IFM), .in2_IFM(in2_IFM),
    .out_valid(out_valid_s), .Out_OFM(out_s), .ovf(ovf_s));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint su;
    longint ss;
    bit     last;
    bit     first;
    int     cyc;
  } beat_t;

  beat_t       pq[$];
  longint      acc_m[2];
  bit          govf_m[2];
  bit          first_m;
  int          cyc_m = 0;
  bit          exp_v;
  logic [31:0] exp_o[2];
  bit          exp_f[2];

  function automatic longint lane_val(input logic [3:0] n, input bit sgn);
    return (sgn && n[3]) ? longint'(n) - 64'sd16 : longint'(n);
  endfunction

  task automatic model_reset();
    pq.delete();
    first_m = 1'b1;
    exp_v   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      acc_m[d]  = 0;
      govf_m[d] = 1'b0;
      exp_o[d]  = 32'd0;
      exp_f[d]  = 1'b0;
    end
  endtask

  task automatic apply_beat(input int d, input longint s, input bit first);
    longint lo, hi, t, u;
    bit step;
    lo = (d == 1) ? -64'sd2048 : 64'sd0;
    hi = (d == 1) ? 64'sd2047 : 64'sd4095;
    if (first) begin
      acc_m[d]  = 0;
      govf_m[d] = 1'b0;
    end
    t = acc_m[d] + s;
    step = (t > hi) || (t < lo);
`ifdef MAC_SATURATE_EN
    if (!govf_m[d]) acc_m[d] = step ? ((t > hi) ? hi : lo) : t;
`else
    u = (t - lo) % 64'sd4096;
    if (u < 0) u = u + 64'sd4096;
    acc_m[d] = u + lo;
`endif
    govf_m[d] = govf_m[d] | step;
  endtask

  // Advance the model by the edge about to sample the current inputs.
  task automatic model_edge();
    beat_t b;
    cyc_m++;
    exp_v = 1'b0;
    if (clr) begin
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].cyc == cyc_m - 1) pq.delete(i);
    end
    if (pq.size() > 0 && pq[0].cyc == cyc_m - 2) begin
      b = pq.pop_front();
      apply_beat(0, b.su, b.first);
      apply_beat(1, b.ss, b.first);
      if (b.last) begin
        exp_v = 1'b1;
        for (int d = 0; d < 2; d++) begin
          exp_o[d] = 32'(acc_m[d] & 64'sd4095);
          exp_f[d] = govf_m[d];
        end
      end
    end
    if (in_valid) begin
      b.su = 0;
      b.ss = 0;
      for (int i = 0; i < 4; i++) begin
        b.su += lane_val(in1_IFM[i*4 +: 4], 1'b0) * lane_val(in2_IFM[i*4 +: 4], 1'b0);
        b.ss += lane_val(in1_IFM[i*4 +: 4], 1'b1) * lane_val(in2_IFM[i*4 +: 4], 1'b1);
      end
      b.first = first_m | clr;
      b.last  = in_last;
      b.cyc   = cyc_m;
      pq.push_back(b);
      first_m = in_last;
    end else if (clr) begin
      first_m = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid_u", {31'd0, out_valid_u}, {31'd0, exp_v});
    check_eq("out_valid_s", {31'd0, out_valid_s}, {31'd0, exp_v});
    check_eq("Out_OFM_u", {20'd0, out_u}, exp_o[0]);
    check_eq("Out_OFM_s", {20'd0, out_s}, exp_o[1]);
    check_eq("ovf_u", {31'd0, ovf_u}, {31'd0, exp_f[0]});
    check_eq("ovf_s", {31'd0, ovf_s}, {31'd0, exp_f[1]});
  endtask

  task automatic cycle(input logic v, input logic l, input logic c,
                       input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_last  = l;
    clr      = c;
    in1_IFM  = a;
    in2_IFM  = b;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 16'hxxxx, 16'hxxxx);
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      clr      = 1'($urandom);
      in1_IFM  = 16'($urandom);
      in2_IFM  = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
    in1_IFM  = 16'h0000;
    in2_IFM  = 16'h0000;
    model_reset();
    @(negedge clk);
    reset_cycles(4);
    idle(4);

    cycle(1'b1, 1'b1, 1'b0, 16'h4321, 16'h5432);
    idle(3);
    check_eq("one_beat", {20'd0, out_u}, 32'd40);

    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001);
    cycle(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0002);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0003);
    cycle(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0004);
    idle(3);
    check_eq("four_beat", {20'd0, out_u}, 32'd20);

    cycle(1'b1, 1'b1, 1'b0, 16'h1111, 16'h1111);
    cycle(1'b1, 1'b1, 1'b0, 16'h2222, 16'h2222);
    idle(1);
    check_eq("b2b_first", {20'd0, out_u}, 32'd4);
    idle(1);
    check_eq("b2b_second", {20'd0, out_u}, 32'd16);
    check_eq("b2b_second_valid", {31'd0, out_valid_u}, 32'd1);
    idle(2);

    for (int j = 0; j < 5; j++) cycle(1'b1, (j == 4), 1'b0, 16'hFFFF, 16'hFFFF);
    idle(3);
`ifdef MAC_SATURATE_EN
    check_eq("ovf_value", {20'd0, out_u}, 32'd4095);
`else
    check_eq("ovf_value", {20'd0, out_u}, 32'd404);
`endif
    check_eq("ovf_flag", {31'd0, ovf_u}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001);
    idle(3);
    check_eq("after_ovf_value", {20'd0, out_u}, 32'd1);
    check_eq("after_ovf_flag", {31'd0, ovf_u}, 32'd0);

    cycle(1'b1, 1'b0, 1'b0, 16'h3333, 16'h3333);
    cycle(1'b1, 1'b0, 1'b0, 16'h3333, 16'h3333);
    cycle(1'b1, 1'b1, 1'b1, 16'h0002, 16'h0002);
    idle(3);
    check_eq("clr_mid_group", {20'd0, out_u}, 32'd4);

    cycle(1'b1, 1'b1, 1'b0, 16'h0F78, 16'h5F87);
    idle(3);
    check_eq("signed_value", {20'd0, out_s}, 32'd3985);
    check_eq("signed_as_unsigned", {20'd0, out_u}, 32'd337);

    cycle(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
    cycle(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
    reset_cycles(2);
    idle(4);
    check_eq("reset_mid_group", {20'd0, out_u}, 32'd0);

    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), 16'($urandom), 16'($urandom));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
